// File: rtl/i3c_daa_multi_slave_pkg.sv
// Shared types and bit-position constants for the multi-identity ENTDAA target engine.
package i3c_daa_pkg;

  typedef enum logic [2:0] {IDLE, ARB, DA, ACK, LOST, DONE} daa_state_t;

  localparam logic [6:0] ID_LAST  = 7'd63;
  localparam logic [6:0] DA_FIRST = 7'd64;
  localparam logic [6:0] PAR_BIT  = 7'd71;
  localparam logic [6:0] ACK_BIT  = 7'd72;

  // Odd parity over the 7-bit dynamic address (parity bit makes total ones odd).
  function automatic logic odd_parity(input logic [6:0] addr);
    return ~^addr;
  endfunction

endpackage

// File: rtl/i3c_daa_multi_slave_arb_mask.sv
// Open-drain arbitration step: surviving-candidate mask, pull-low request and
// lowest-index priority encoder over the survivors.
module i3c_daa_arb_mask #(
  parameter int N_TGT = 2,
  parameter int IDX_W = 3
) (
  input  logic [N_TGT-1:0] cand,
  input  logic [N_TGT-1:0] idbit,
  input  logic             sda_in,
  output logic [N_TGT-1:0] cand_next,
  output logic             drv_low,
  output logic [IDX_W-1:0] low_idx,
  output logic             multi
);

  assign drv_low   = |(cand & ~idbit);
  assign cand_next = cand & ~(idbit ^ {N_TGT{sda_in}});
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi     = |(cand_next & (cand_next - N_TGT'(1)));

  always_comb begin
    low_idx = '0;
    for (int i = N_TGT - 1; i >= 0; i--) begin
      if (cand_next[i]) low_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/i3c_daa_multi_slave.sv
// ENTDAA target engine hosting N_TGT identities on one SDA/SCL pair, with direct sets and RSTDAA.
// Optional macro I3C_DAA_PARITY_CHK_EN: NACK and skip the commit when the address parity is wrong.
module i3c_daa_multi_slave
  import i3c_daa_pkg::*;
#(
  parameter int               N_TGT   = 2,
  parameter int               IDX_W   = 3,
  parameter logic [N_TGT-1:0] TGT_ENA = {N_TGT{1'b1}}
) (
  input  logic                 clk_SCL,
  input  logic                 RSTn,
  input  logic                 daa_active,
  input  logic                 sda_in,
  input  logic [N_TGT*64-1:0]  id_flat,
  input  logic                 set_da,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic [6:0]           set_addr,
  input  logic                 rstdaa,
  output logic                 sda_drv_low,
  output logic [N_TGT*8-1:0]   dyn_addr,
  output logic                 da_chg,
  output logic [IDX_W-1:0]     da_chg_idx,
  output logic [IDX_W-1:0]     win_idx,
  output logic                 id_collision,
  output logic                 all_assigned
);

  daa_state_t       state_reg;
  logic [6:0]       cnt_reg;
  logic [6:0]       addr_reg;
  logic             par_reg;
  logic [N_TGT-1:0] cand_reg;
  logic [N_TGT-1:0] valid_reg;
  logic [6:0]       da_reg [N_TGT];
  logic [IDX_W-1:0] win_reg;
  logic [IDX_W-1:0] chg_idx_reg;
  logic             da_chg_reg;
  logic             coll_reg;

  logic [N_TGT-1:0] idbit;
  logic [N_TGT-1:0] cand_next;
  logic [IDX_W-1:0] low_idx;
  logic             multi;
  logic             arb_drv;
  logic             par_ok;
  logic             set_ok;
  logic             commit;

  generate
    for (genvar gi = 0; gi < N_TGT; gi++) begin : g_tgt
      logic [63:0] id_w;
      assign id_w                = id_flat[64*gi +: 64];
      assign idbit[gi]           = id_w[~cnt_reg[5:0]];
      assign dyn_addr[8*gi +: 8] = {da_reg[gi], valid_reg[gi]};
    end
  endgenerate

  i3c_daa_arb_mask #(.N_TGT(N_TGT), .IDX_W(IDX_W)) u_arb (
    .cand      (cand_reg),
    .idbit     (idbit),
    .sda_in    (sda_in),
    .cand_next (cand_next),
    .drv_low   (arb_drv),
    .low_idx   (low_idx),
    .multi     (multi)
  );

`ifdef I3C_DAA_PARITY_CHK_EN
  assign par_ok = (par_reg == odd_parity(addr_reg));
`else
  // Parity is captured but never disqualifies the address: always ACK.
  assign par_ok = par_reg | ~par_reg;
`endif

  assign set_ok = set_da && (int'(set_idx) < N_TGT);
  assign commit = (state_reg == ACK) && daa_active && par_ok && (cnt_reg == ACK_BIT);

  always_comb begin
    sda_drv_low = 1'b0;
    case (state_reg)
      ARB:     sda_drv_low = arb_drv;
      ACK:     sda_drv_low = par_ok;
      default: sda_drv_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk_SCL or negedge RSTn) begin
    if (!RSTn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      par_reg     <= 1'b0;
      cand_reg    <= '0;
      valid_reg   <= '0;
      win_reg     <= '0;
      chg_idx_reg <= '0;
      da_chg_reg  <= 1'b0;
      coll_reg    <= 1'b0;
      for (int i = 0; i < N_TGT; i++) da_reg[i] <= '0;
    end else begin
      da_chg_reg <= 1'b0;

      if (!daa_active) begin
        state_reg <= IDLE;
        cand_reg  <= '0;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            cnt_reg   <= '0;
            cand_reg  <= TGT_ENA & ~valid_reg;
            state_reg <= ((TGT_ENA & ~valid_reg) == '0) ? LOST : ARB;
          end
          ARB: begin
            cand_reg <= cand_next;
            cnt_reg  <= cnt_reg + 7'd1;
            if (cand_next == '0) begin
              state_reg <= LOST;
            end else if (cnt_reg == ID_LAST) begin
              win_reg   <= low_idx;
              if (multi) coll_reg <= 1'b1;
              state_reg <= DA;
            end
          end
          DA: begin
            cnt_reg <= cnt_reg + 7'd1;
            if (cnt_reg == PAR_BIT) begin
              par_reg   <= sda_in;
              state_reg <= ACK;
            end else if (cnt_reg >= DA_FIRST) begin
              addr_reg <= {addr_reg[5:0], sda_in};
            end
          end
          ACK:     state_reg <= DONE;
          default: state_reg <= state_reg;
        endcase
      end

      // Address table updates: rstdaa beats set_da beats the round's own commit.
      if (rstdaa) begin
        valid_reg   <= '0;
        da_chg_reg  <= 1'b1;
        chg_idx_reg <= '1;
      end else if (set_ok) begin
        for (int i = 0; i < N_TGT; i++) begin
          if (set_idx == IDX_W'(i)) begin
            da_reg[i]    <= set_addr;
            valid_reg[i] <= 1'b1;
          end
        end
        da_chg_reg  <= 1'b1;
        chg_idx_reg <= set_idx;
      end else if (commit) begin
        for (int i = 0; i < N_TGT; i++) begin
          if (win_reg == IDX_W'(i)) begin
            da_reg[i]    <= addr_reg;
            valid_reg[i] <= 1'b1;
          end
        end
        da_chg_reg  <= 1'b1;
        chg_idx_reg <= win_reg;
      end
    end
  end

  assign da_chg       = da_chg_reg;
  assign da_chg_idx   = chg_idx_reg;
  assign win_idx      = win_reg;
  assign id_collision = coll_reg;
  assign all_assigned = &(valid_reg | ~TGT_ENA);

endmodule
